key_click_decoder: RTL and testbench



---
 rtl/key_pkg.sv | 13 +
 rtl/key_gap_timer.sv | 34 +++
 rtl/key_click_decoder.sv | 97 +++++++++
 tb/tb_key_click_decoder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared click-decoder state type and default timing constants
package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } click_state_e;

  localparam int GAP_CYCLES_DEF = 50;
  localparam int MAX_CLICKS_DEF = 4;

endpackage

// File: rtl/key_gap_timer.sv
// rtl/key_gap_timer.sv - inter-click gap timer, saturating at GAP_CYCLES-1
module key_gap_timer
  import key_pkg::*;
#(
  parameter  int GAP_CYCLES = GAP_CYCLES_DEF,
  localparam int TW         = $clog2(GAP_CYCLES)
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (GAP_CYCLES < 2) begin : g_bad_gap
    $error("key_gap_timer: GAP_CYCLES must be >= 2");
  end

  logic [TW-1:0] timer;

  assign expired = (timer == TW'(GAP_CYCLES - 1));

  // Holding at the expiry value keeps the counter from ever wrapping.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      timer <= '0;
    end else if (clear) begin
      timer <= '0;
    end else if (enable && !expired) begin
      timer <= timer + 1'b1;
    end
  end

endmodule

// File: rtl/key_click_decoder.sv
// rtl/key_click_decoder.sv - groups debounced key strobes into click bursts with a valid/ready result
module key_click_decoder
  import key_pkg::*;
#(
  parameter  int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter  int MAX_CLICKS = MAX_CLICKS_DEF,
  localparam int CNT_W      = $clog2(MAX_CLICKS + 1)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             key_pressed_stb_i,
  output logic             click_valid_o,
  output logic [CNT_W-1:0] click_count_o,
  output logic             click_sat_o,
  input  logic             click_ready_i,
  output logic             busy_o,
  output logic             drop_stb_o
);

  if (GAP_CYCLES < 2) begin : g_bad_gap
    $error("key_click_decoder: GAP_CYCLES must be >= 2");
  end
  if (MAX_CLICKS < 2) begin : g_bad_max
    $error("key_click_decoder: MAX_CLICKS must be >= 2");
  end

  click_state_e state;
  logic         gap_expired;

  // Every strobe and every cycle outside COUNT restarts the gap measurement.
  key_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap_timer (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clear  (key_pressed_stb_i || (state != COUNT)),
    .enable (state == COUNT),
    .expired(gap_expired)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= IDLE;
      click_count_o <= '0;
      click_sat_o   <= 1'b0;
      click_valid_o <= 1'b0;
      busy_o        <= 1'b0;
      drop_stb_o    <= 1'b0;
    end else begin
      drop_stb_o <= 1'b0;
      case (state)
        IDLE: begin
          if (key_pressed_stb_i) begin
            state         <= COUNT;
            click_count_o <= CNT_W'(1);
            click_sat_o   <= 1'b0;
            busy_o        <= 1'b1;
          end
        end
        COUNT: begin
          // A strobe landing on the expiry cycle extends the burst.
          if (key_pressed_stb_i) begin
            if (click_count_o < CNT_W'(MAX_CLICKS)) begin
              click_count_o <= click_count_o + 1'b1;
            end else begin
              click_sat_o <= 1'b1;
            end
          end else if (gap_expired) begin
            state         <= REPORT;
            click_valid_o <= 1'b1;
          end
        end
        REPORT: begin
          if (click_ready_i) begin
            click_valid_o <= 1'b0;
            if (key_pressed_stb_i) begin
              state         <= COUNT;
              click_count_o <= CNT_W'(1);
              click_sat_o   <= 1'b0;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else if (key_pressed_stb_i) begin
            drop_stb_o <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          click_valid_o <= 1'b0;
          busy_o        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_click_decoder.sv
// tb/tb_key_click_decoder.sv - self-checking bench for key_click_decoder against a timing-rule model
module tb_key_click_decoder;

  localparam int GAP  = 50;
  localparam int MAXC = 4;
  localparam int CW   = $clog2(MAXC + 1);

  logic          clk   = 1'b0;
  logic          rstn  = 1'b0;
  logic          stb   = 1'b0;
  logic          ready = 1'b1;
  logic          valid, sat, busy, drop;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  key_click_decoder #(
    .GAP_CYCLES(GAP),
    .MAX_CLICKS(MAXC)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .key_pressed_stb_i(stb),
    .click_valid_o    (valid),
    .click_count_o    (cnt),
    .click_sat_o      (sat),
    .click_ready_i    (ready),
    .busy_o           (busy),
    .drop_stb_o       (drop)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int res(input int c, input int s);
    return s * (1 << CW) + c;
  endfunction

  // Model: a burst continues while strobes are at most GAP edges apart; it is
  // reported GAP edges after its last strobe and held until accepted.
  int cyc = 0;
  int m_n = 0;
  int m_last = 0;
  bit m_active = 0, m_pend = 0, m_drop = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_active = 0; m_pend = 0; m_drop = 0; m_n = 0;
    end else begin
      cyc++;
      m_drop = 0;
      if (m_pend) begin
        if (ready) begin
          m_pend = 0;
          if (stb) begin m_active = 1; m_n = 1; m_last = cyc; end
        end else if (stb) begin
          m_drop = 1;
        end
      end else if (m_active) begin
        if (stb) begin
          m_n++; m_last = cyc;
        end else if (cyc - m_last == GAP) begin
          m_active = 0; m_pend = 1;
        end
      end else if (stb) begin
        m_active = 1; m_n = 1; m_last = cyc;
      end
    end
  end

  bit chk_en = 0;
  int res_q[$];
  int drop_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", 32'(valid), 32'(m_pend));
      check("busy", 32'(busy), 32'(m_active || m_pend));
      check("drop", 32'(drop), 32'(m_drop));
      if (m_pend) begin
        check("count", 32'(cnt), 32'((m_n > MAXC) ? MAXC : m_n));
        check("sat", 32'(sat), 32'(m_n > MAXC));
      end
      if (valid && ready) res_q.push_back(res(int'(cnt), int'(sat)));
      if (drop) drop_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    stb = 1'b1;
    tick();
    stb = 1'b0;
  endtask

  // Edges from the last strobe's sampling edge until valid is seen; 999 on timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid && lat < 200) begin
      tick();
      lat++;
    end
    if (!valid) lat = 999;
  endtask

  task automatic pop_result(output int r);
    int k = 0;
    while (res_q.size() == 0 && k < 200) begin
      tick();
      k++;
    end
    if (res_q.size() == 0) r = -1;
    else r = res_q.pop_front();
  endtask

  task automatic async_reset_check(input string name);
    #2 rstn = 1'b0;
    #2;
    check({name, "_valid"}, 32'(valid), 0);
    check({name, "_count"}, 32'(cnt), 0);
    check({name, "_sat"}, 32'(sat), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_drop"}, 32'(drop), 0);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, r, density;

    @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 0);
    check("rst_count", 32'(cnt), 0);
    check("rst_busy", 32'(busy), 0);
    chk_en = 1;
    tick(2);
    rstn = 1'b1;
    tick(2);

    // Single strobe: latency GAP edges, count 1.
    pulse();
    wait_valid(lat);
    check("t1_latency", lat, GAP);
    pop_result(r);
    check("t1_result", r, res(1, 0));
    check("t1_busy_after", 32'(busy), 0);
    tick(5);

    // Three strobes 20 cycles apart.
    pulse(); tick(19); pulse(); tick(19); pulse();
    wait_valid(lat);
    check("t2_latency", lat, GAP);
    pop_result(r);
    check("t2_result", r, res(3, 0));
    tick(5);
    check("t2_no_extra", res_q.size(), 0);

    // Six strobes 10 apart saturate, then a single click.
    for (int i = 0; i < 6; i++) begin
      pulse();
      if (i < 5) tick(9);
    end
    pop_result(r);
    check("t3_sat", r, res(4, 1));
    tick(3);
    pulse();
    pop_result(r);
    check("t3_single", r, res(1, 0));
    tick(5);

    // Back-pressure with a dropped strobe.
    ready = 1'b0;
    drop_cnt = 0;
    pulse(); tick(1); pulse();
    wait_valid(lat);
    for (int i = 0; i < 30; i++) begin
      stb = (i == 10);
      tick();
    end
    stb = 1'b0;
    check("t4_held_valid", 32'(valid), 1);
    check("t4_held_count", 32'(cnt), 2);
    check("t4_drops", drop_cnt, 1);
    ready = 1'b1;
    pop_result(r);
    check("t4_result", r, res(2, 0));
    tick(2);
    check("t4_idle", 32'(busy), 0);

    // Gap boundaries: 49 and 50 edges extend the burst, 51 starts a new one.
    pulse(); tick(48); pulse();
    pop_result(r);
    check("t5_gap49", r, res(2, 0));
    tick(5);
    pulse(); tick(49); pulse();
    pop_result(r);
    check("t5_gap50", r, res(2, 0));
    tick(5);
    pulse(); tick(50); pulse();
    pop_result(r);
    check("t5_gap51_a", r, res(1, 0));
    pop_result(r);
    check("t5_gap51_b", r, res(1, 0));
    tick(5);

    // Asynchronous reset mid-burst and during a held report.
    pulse(); tick(9); pulse(); tick(5);
    async_reset_check("t6_count");
    tick(GAP + 10);
    check("t6_discarded", res_q.size(), 0);
    ready = 1'b0;
    pulse();
    wait_valid(lat);
    tick(3);
    async_reset_check("t6_report");
    ready = 1'b1;
    tick(3);
    check("t6_discarded2", res_q.size(), 0);
    pulse();
    pop_result(r);
    check("t6_fresh", r, res(1, 0));
    tick(5);

    // Randomized strobes and back-pressure, checked every cycle by the model.
    for (int blk = 0; blk < 12; blk++) begin
      density = (blk % 3 == 0) ? 2 : ((blk % 3 == 1) ? 6 : 30);
      for (int i = 0; i < 250; i++) begin
        stb   = ($urandom_range(0, 99) < density);
        ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    end
    stb = 1'b0;
    ready = 1'b1;
    tick(GAP + 20);
    check("rand_drained", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL global_timeout: got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
